// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory access stage of the toothless RV32I core. Takes the decoder's
//   memory controls, the ALU result as effective byte address and rs2 as store
//   data, runs a req/gnt/rvalid transaction on the data-memory port, stalls the
//   core while it is outstanding and returns aligned, extended load data.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   data_req_i          memory instruction present in EX
//   data_we_i           1 store, 0 load
//   data_type_i         00 word, 01 half, 10 byte, 11 reserved
//   data_sign_ext_i     sign-extend load data (LB/LH), else zero-extend
//   addr_i, wdata_i     effective byte address, store data
//   busy_o              stall request to the core
//   misaligned_o        access rejected (misaligned or reserved type)
//   rdata_o             extended load result, held until the next load
//   rdata_valid_o       one-cycle pulse when rdata_o is new
//   mem_req_o/mem_gnt_i request handshake to data memory
//   mem_addr_o          word-aligned address
//   mem_we_o, mem_be_o  write enable, byte enables
//   mem_wdata_o         lane-replicated store data
//   mem_rvalid_i        response valid (loads and stores)
//   mem_rdata_i         raw read word
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [1:0]            data_type_i,
  input  logic                  data_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  misaligned_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [1:0] TYPE_WORD = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_BYTE = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  state_t                r_state;
  logic                  r_we;
  logic [1:0]            r_type;
  logic                  r_sext;
  logic [1:0]            r_off;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [3:0]            r_mem_be;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  logic                  w_bad;
  logic                  w_idle;
  logic                  w_accept;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_load;

  // Reserved type is rejected along with misaligned addresses.
  always_comb begin
    w_bad = 1'b0;
    case (data_type_i)
      TYPE_WORD: w_bad = (addr_i[1:0] != 2'b00);
      TYPE_HALF: w_bad = addr_i[0];
      TYPE_BYTE: w_bad = 1'b0;
      default:   w_bad = 1'b1;
    endcase
  end

  assign w_idle       = (r_state == IDLE);
  assign misaligned_o = w_idle & data_req_i & w_bad;
  assign w_accept     = w_idle & data_req_i & ~w_bad;
  // Stall is raised in the accept cycle itself so the core holds EX.
  assign busy_o       = ~w_idle | w_accept;

  // Byte enables and lane replication for the store side.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    case (data_type_i)
      TYPE_HALF: begin
        w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata_i[15:0]}};
      end
      TYPE_BYTE: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
      end
    endcase
  end

  // Load extraction uses the latched offset/type, not the live inputs.
  assign w_shifted = mem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_type)
      TYPE_BYTE: w_load = {{(DATA_WIDTH-8){r_sext & w_shifted[7]}},  w_shifted[7:0]};
      TYPE_HALF: w_load = {{(DATA_WIDTH-16){r_sext & w_shifted[15]}}, w_shifted[15:0]};
      default:   w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_type      <= TYPE_WORD;
      r_sext      <= 1'b0;
      r_off       <= 2'b00;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= data_we_i;
            r_type      <= data_type_i;
            r_sext      <= data_sign_ext_i;
            r_off       <= addr_i[1:0];
            r_mem_req   <= 1'b1;
            r_mem_we    <= data_we_i;
            r_mem_addr  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_state     <= REQ;
          end
        end
        REQ: begin
          // mem_* stay frozen until granted; rvalid here is spurious.
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            r_state <= IDLE;
            if (!r_we) begin
              r_rdata  <= w_load;
              r_rvalid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req_o     = r_mem_req;
  assign mem_we_o      = r_mem_we;
  assign mem_addr_o    = r_mem_addr;
  assign mem_be_o      = r_mem_be;
  assign mem_wdata_o   = r_mem_wdata;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rvalid;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        data_req_i;
  logic        data_we_i;
  logic [1:0]  data_type_i;
  logic        data_sign_ext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        misaligned_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_chk;
  int n_fail;
  logic [31:0] last_rd;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_type_i(data_type_i),
    .data_sign_ext_i(data_sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .misaligned_o(misaligned_o), .rdata_o(rdata_o),
    .rdata_valid_o(rdata_valid_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic from the access rules.
  function automatic bit m_bad(input logic [1:0] typ, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (typ == 2'd3) return 1'b1;
    if (typ == 2'd0) return off != 0;
    if (typ == 2'd1) return (off % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] typ, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (typ == 2'd0) return 4'hF;
    if (typ == 2'd1) return 4'(3 * (1 << off));
    return 4'(1 << off);
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] typ, input logic [31:0] w);
    if (typ == 2'd0) return w;
    if (typ == 2'd1) return (w % 65536) * 32'h0001_0001;
    return (w % 256) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] typ, input logic sx,
                                       input logic [31:0] a, input logic [31:0] word);
    longint v;
    int off;
    off = int'(a % 4);
    v = longint'(word) / (longint'(1) << (8 * off));
    if (typ == 2'd2) begin
      v = v % 256;
      if (sx && v >= 128) v = v - 256;
    end else if (typ == 2'd1) begin
      v = v % 65536;
      if (sx && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  // One full access: request, gd cycles without grant, rd cycles without
  // response, then check the release cycle. All sampling #1 after negedge.
  task automatic do_access(input logic we, input logic [1:0] typ, input logic sx,
                           input logic [31:0] a, input logic [31:0] w, input logic [31:0] rword,
                           input int gd, input int rd, input bit spur,
                           input logic [3:0] ebe, input logic [31:0] ewd,
                           input logic [31:0] erd, input bit emis);
    @(negedge clk);
    data_req_i = 1'b1; data_we_i = we; data_type_i = typ; data_sign_ext_i = sx;
    addr_i = a; wdata_i = w; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #1;
    chk("misaligned_o", 32'(misaligned_o), 32'(emis));
    chk("busy_accept", 32'(busy_o), 32'(!emis));
    chk("req_low_accept", 32'(mem_req_o), 32'd0);
    if (emis) begin
      @(negedge clk); #1;
      chk("mis_no_req", 32'(mem_req_o), 32'd0);
      chk("mis_busy", 32'(busy_o), 32'd0);
      data_req_i = 1'b0;
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      @(negedge clk);
      mem_gnt_i    = (i == gd);
      mem_rvalid_i = spur && (i == 0) && (gd > 0);
      mem_rdata_i  = ~rword;
      #1;
      chk("mem_req", 32'(mem_req_o), 32'd1);
      chk("mem_addr", mem_addr_o, {a[31:2], 2'b00});
      chk("mem_be", 32'(mem_be_o), 32'(ebe));
      chk("mem_we", 32'(mem_we_o), 32'(we));
      if (we) chk("mem_wdata", mem_wdata_o, ewd);
      chk("busy_req", 32'(busy_o), 32'd1);
      chk("no_valid_req", 32'(rdata_valid_o), 32'd0);
    end
    for (int i = 0; i <= rd; i++) begin
      @(negedge clk);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = (i == rd);
      mem_rdata_i  = rword;
      #1;
      chk("req_dropped", 32'(mem_req_o), 32'd0);
      chk("busy_wait", 32'(busy_o), 32'd1);
    end
    @(negedge clk);
    mem_rvalid_i = 1'b0; data_req_i = 1'b0; mem_rdata_i = 32'h0;
    #1;
    chk("busy_release", 32'(busy_o), 32'd0);
    chk("rdata_valid", 32'(rdata_valid_o), 32'(!we));
    chk("rdata", rdata_o, erd);
    @(negedge clk); #1;
    chk("valid_pulse_end", 32'(rdata_valid_o), 32'd0);
    chk("rdata_hold", rdata_o, erd);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  typ;
    logic        sx;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] rword;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
    bit          emis;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [31:0] ra, rw, rword, erd;
    logic [1:0]  rt;
    logic        rwe, rsx;
    bit          mis;

    n_chk = 0; n_fail = 0; last_rd = 32'h0;
    rst_n = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_type_i = 2'b00;
    data_sign_ext_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    vt[0]  = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[1]  = '{1'b0, 2'd2, 1'b1, 32'h103, 32'h0,        32'h80112233, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0};
    vt[2]  = '{1'b0, 2'd2, 1'b0, 32'h103, 32'h0,        32'h80112233, 4'h8, 32'h0,        32'h00000080, 1'b0};
    vt[3]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h0,        4'hC, 32'hABCDABCD, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vt[5]  = '{1'b0, 2'd1, 1'b1, 32'h103, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vt[6]  = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vt[7]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h80011234, 4'hC, 32'h0,        32'hFFFF8001, 1'b0};
    vt[8]  = '{1'b0, 2'd1, 1'b0, 32'h000, 32'h0,        32'h1234F00D, 4'h3, 32'h0,        32'h0000F00D, 1'b0};
    vt[9]  = '{1'b1, 2'd0, 1'b0, 32'h010, 32'h12345678, 32'h0,        4'hF, 32'h12345678, 32'h0,        1'b0};
    vt[10] = '{1'b1, 2'd2, 1'b0, 32'h003, 32'h000000A5, 32'h0,        4'h8, 32'hA5A5A5A5, 32'h0,        1'b0};
    vt[11] = '{1'b0, 2'd2, 1'b1, 32'h001, 32'h0,        32'h00007F00, 4'h2, 32'h0,        32'h0000007F, 1'b0};

    #2;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_be", 32'(mem_be_o), 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_valid", 32'(rdata_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, immediate grant and next-cycle response.
    for (int k = 0; k < 12; k++) begin
      if (!vt[k].we && !vt[k].emis) erd = vt[k].erd; else erd = last_rd;
      do_access(vt[k].we, vt[k].typ, vt[k].sx, vt[k].a, vt[k].w, vt[k].rword,
                0, 0, 1'b0, vt[k].ebe, vt[k].ewd, erd, vt[k].emis);
      last_rd = erd;
    end

    // Delayed grant (3) and response (2) with a spurious rvalid during REQ.
    do_access(1'b0, 2'd0, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 3, 2, 1'b1,
              4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    last_rd = 32'hCAFEF00D;

    // Reset while waiting for the response.
    @(negedge clk);
    data_req_i = 1'b1; data_we_i = 1'b0; data_type_i = 2'd0; addr_i = 32'h400;
    @(negedge clk);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    #1;
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    data_req_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req_o), 32'd0);
    chk("arst_mem_we", 32'(mem_we_o), 32'd0);
    chk("arst_mem_addr", mem_addr_o, 32'h0);
    chk("arst_mem_be", 32'(mem_be_o), 32'd0);
    chk("arst_mem_wdata", mem_wdata_o, 32'h0);
    chk("arst_rdata", rdata_o, 32'h0);
    chk("arst_valid", 32'(rdata_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
    do_access(1'b1, 2'd2, 1'b0, 32'h001, 32'h0000003C, 32'h0, 0, 0, 1'b0,
              4'h2, 32'h3C3C3C3C, 32'h0, 1'b0);

    // Randomized accesses against the reference model.
    for (int k = 0; k < 60; k++) begin
      rwe = 1'($urandom_range(0, 1));
      rt  = 2'($urandom_range(0, 3));
      rsx = 1'($urandom_range(0, 1));
      ra  = $urandom;
      if ($urandom_range(0, 1) == 0) ra = ra & 32'hFFFF_FFFC;
      rw  = $urandom;
      rword = $urandom;
      mis = m_bad(rt, ra);
      erd = (!rwe && !mis) ? m_ld(rt, rsx, ra, rword) : last_rd;
      do_access(rwe, rt, rsx, ra, rw, rword, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), m_be(rt, ra), m_wd(rt, rw), erd, mis);
      last_rd = erd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the toothless RV32I core. It sits directly downstream of the fetch/decode/execute stage. It consumes that stage's decoder memory controls (request, type, write enable, sign-extend) together with the ALU result as the effective address and rs2 as store data. It runs a request/grant/response transaction on the data-memory port, stalls the core while the access is outstanding, and returns aligned, extended load data for register write-back.

## Interface
Parameters:
- DATA_WIDTH, 32, data width; only 32 supported
- ADDR_WIDTH, 32, byte-address width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- data_req_i  in  1  memory instruction present in EX
- data_we_i  in  1  1 store, 0 load
- data_type_i  in  2  00 word, 01 half, 10 byte, 11 reserved
- data_sign_ext_i  in  1  sign-extend load data (LB/LH); 0 zero-extends (LBU/LHU)
- addr_i  in  ADDR_WIDTH  effective byte address (ALU result)
- wdata_i  in  DATA_WIDTH  store data (rs2)
- busy_o  out  1  stall request to core
- misaligned_o  out  1  access rejected (misaligned or reserved type)
- rdata_o  out  DATA_WIDTH  extended load result
- rdata_valid_o  out  1  one-cycle pulse, rdata_o new
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory accepted request
- mem_addr_o  out  ADDR_WIDTH  word-aligned address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  DATA_WIDTH  lane-replicated store data
- mem_rvalid_i  in  1  response valid (loads and stores)
- mem_rdata_i  in  DATA_WIDTH  raw word read data

## Operation
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE: inputs are sampled only in this state.
  - data_req_i=1 and aligned: latch the access; go to REQ.
  - Latched fields: we, type, sign_ext, addr[1:0].
  - Memory output registers load with mem_req_o=1, mem_addr_o={addr_i[31:2],2'b00}, mem_we_o, mem_be_o, mem_wdata_o.
- REQ: hold all mem_* outputs stable. On mem_gnt_i, clear mem_req_o and go to WAIT_RSP.
- WAIT_RSP: on mem_rvalid_i, go to IDLE.
  - Load: register the extracted/extended data into rdata_o and pulse rdata_valid_o.
  - Store: no rdata_valid_o pulse.
- Misalignment rule: word with addr[1:0]≠0, half with addr[0]=1, or type 11.
  - misaligned_o=1 combinationally in that IDLE cycle.
  - No memory access, busy_o stays 0, FSM stays in IDLE.
- busy_o = (state≠IDLE) | (state==IDLE & data_req_i & !misaligned). Combinational.
- Byte enables:
  - word: 1111
  - half: 0011 at offset 0, 1100 at offset 2
  - byte: 0001<<addr[1:0]
- Store data:
  - word: wdata_i
  - half: {2{wdata_i[15:0]}}
  - byte: {4{wdata_i[7:0]}}
  - Byte lanes not enabled are don't-care to memory.
- Load extraction:
  - shifted = mem_rdata_i >> (8*offset)
  - byte: bit 7 extended; half: bit 15 extended; word: passed unchanged.
  - Sign extension when sign_ext=1, otherwise zero extension.
- mem_rvalid_i outside WAIT_RSP is ignored. mem_gnt_i outside REQ is ignored.

## Timing
- Reset values: state IDLE; mem_req_o, mem_we_o, rdata_valid_o = 0; mem_addr_o, mem_be_o, mem_wdata_o, rdata_o = 0.
- Reset mid-transaction abandons the access immediately. The memory side must tolerate request withdrawal on reset.
- Accept cycle T (busy_o=1). mem_req_o rises at T+1.
- Grant at cycle G ≥ T+1: mem_req_o falls at G+1.
- The memory rule for mem_rvalid_i is decided: earliest at G+1, never in the grant cycle.
- Response at cycle R: busy_o stays 1 through R.
- At R+1: state IDLE, busy_o=0, rdata_valid_o=1 (loads only).
- Best-case load: T+3 to valid data and release; the core advances in that cycle.
- The core holds data_req_i and operands stable while busy_o=1. They are not re-sampled until IDLE.
- A new request may be accepted in the same cycle rdata_valid_o pulses.
- rdata_o holds its value until the next load completes.

## Test plan
- Aligned LW, addr 0x100, memory grants immediately and returns 0xDEADBEEF the next cycle:
  - mem_addr_o=0x100, be=1111.
  - rdata_o=0xDEADBEEF with valid at T+3; busy_o high T..T+2.
- LB / LBU, addr 0x103, mem_rdata 0x80112233:
  - signed: rdata_o=0xFFFFFF80.
  - unsigned: rdata_o=0x00000080.
- SH, addr 0x202, wdata 0x0000ABCD:
  - mem_addr_o=0x200, be=1100, mem_wdata_o=0xABCDABCD, mem_we_o=1.
  - No rdata_valid_o pulse.
- Misaligned requests: LW at 0x101, LH at 0x103, type 11:
  - misaligned_o=1 same cycle, busy_o=0, mem_req_o never asserted.
- Grant delayed 3 cycles and rvalid delayed 2 more:
  - mem_req_o and all mem_* stable until grant; busy_o high throughout.
  - A spurious rvalid during REQ is ignored.
- rst_n asserted in WAIT_RSP:
  - All outputs 0 asynchronously, state IDLE.
  - After release, a new SB at 0x001 gives be=0010.
